// File: rtl/icache_line_fill.sv
// Line refill bridge: turns one icache line miss into BEATS sequential bus word
// reads, assembles the words into a line and returns it with a one-cycle ack.
module icache_line_fill #(
  parameter int ADDR_WIDTH = 32,
  parameter int LINE_WIDTH = 128,
  parameter int BUS_WIDTH  = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req_i,
  input  logic [ADDR_WIDTH-1:0] addr_i,
  input  logic                  kill_i,
  output logic                  ack_o,
  output logic [LINE_WIDTH-1:0] r_data_o,
  output logic                  busy_o,
  output logic                  bus_req_o,
  output logic [ADDR_WIDTH-1:0] bus_addr_o,
  input  logic                  bus_ack_i,
  input  logic [BUS_WIDTH-1:0]  bus_rdata_i
);

  localparam int BEATS      = LINE_WIDTH / BUS_WIDTH;
  localparam int BEAT_BITS  = $clog2(BEATS);
  localparam int LINE_OFF   = $clog2(LINE_WIDTH / 8);
  localparam int WORD_BYTES = BUS_WIDTH / 8;

  typedef enum logic [1:0] {
    IDLE,
    BEAT,
    DRAIN,
    RESP
  } state_t;

  state_t                state;
  logic [BEAT_BITS-1:0]  beat;
  logic [LINE_WIDTH-1:0] buffer;
  logic [ADDR_WIDTH-1:0] line_base;
  logic                  abort;

  assign abort     = kill_i | ~req_i;
  assign line_base = addr_i & ~ADDR_WIDTH'((1 << LINE_OFF) - 1);

  assign busy_o   = (state != IDLE);
  assign ack_o    = (state == RESP) & ~abort;
  assign r_data_o = buffer;

  // bus_addr_o is kept as a running word address so it never depends on
  // live inputs; once a read is issued it is held until the bus acks it.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= IDLE;
      beat       <= '0;
      buffer     <= '0;
      bus_req_o  <= 1'b0;
      bus_addr_o <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (req_i && !kill_i) begin
            beat       <= '0;
            bus_addr_o <= line_base;
            bus_req_o  <= 1'b1;
            state      <= BEAT;
          end
        end
        BEAT: begin
          if (bus_ack_i) begin
            if (abort) begin
              bus_req_o <= 1'b0;
              state     <= IDLE;
            end else begin
              buffer[beat*BUS_WIDTH +: BUS_WIDTH] <= bus_rdata_i;
              if (beat == BEAT_BITS'(BEATS - 1)) begin
                bus_req_o <= 1'b0;
                state     <= RESP;
              end else begin
                beat       <= beat + BEAT_BITS'(1);
                bus_addr_o <= bus_addr_o + ADDR_WIDTH'(WORD_BYTES);
              end
            end
          end else if (abort) begin
            state <= DRAIN;
          end
        end
        // An issued read cannot be retracted, so wait it out and drop the data.
        DRAIN: begin
          if (bus_ack_i) begin
            bus_req_o <= 1'b0;
            state     <= IDLE;
          end
        end
        RESP: begin
          state <= IDLE;
        end
        default: begin
          bus_req_o <= 1'b0;
          state     <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_icache_line_fill.sv
// Directed and randomized line fills checked cycle by cycle against an
// expected bus address / line / ack timeline computed inside the bench.
module tb_icache_line_fill;

  localparam int K_NONE     = 0;
  localparam int K_KILL     = 1;
  localparam int K_DROP     = 2;
  localparam int K_KILL_ACK = 3;
  localparam int K_RESET    = 4;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         req;
  logic [31:0]  addr;
  logic         kill;
  logic         ack;
  logic [127:0] r_data;
  logic         busy;
  logic         bus_req;
  logic [31:0]  bus_addr;
  logic         bus_ack;
  logic [31:0]  bus_rdata;

  int tests  = 0;
  int failed = 0;

  icache_line_fill dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .req_i       (req),
    .addr_i      (addr),
    .kill_i      (kill),
    .ack_o       (ack),
    .r_data_o    (r_data),
    .busy_o      (busy),
    .bus_req_o   (bus_req),
    .bus_addr_o  (bus_addr),
    .bus_ack_i   (bus_ack),
    .bus_rdata_i (bus_rdata)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("[TB] FAIL watchdog expired");
    $fatal(1, "[TB] watchdog");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_output(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_bus(input string tag, input logic exp_busy, input logic exp_req,
                           input logic [31:0] exp_addr, input logic exp_ack);
    check_output({tag, ".busy"}, busy, exp_busy);
    check_output({tag, ".bus_req"}, bus_req, exp_req);
    check_output({tag, ".ack"}, ack, exp_ack);
    if (exp_req) check_output({tag, ".bus_addr"}, bus_addr, exp_addr);
  endtask

  // An idle cycle; a request raised together with kill must not be accepted.
  task automatic idle_step();
    req       = 1'($urandom_range(0, 1));
    kill      = req;
    addr      = $urandom;
    bus_ack   = 1'($urandom_range(0, 1));
    bus_rdata = $urandom;
    #1;
    check_bus("idle", 1'b0, 1'b0, 32'h0, 1'b0);
    step();
  endtask

  // One icache request from acceptance through ack, abort or reset.
  // ab_beat 0..3 selects a beat; 4 selects the response cycle.
  task automatic fill(input logic [31:0] a, input int waits, input int ab_beat,
                      input int kind, input int drain_wait, input bit fixed);
    logic [31:0]  base;
    logic [31:0]  w;
    logic [127:0] line;
    bit           aborted;
    bit           last;
    bit           ab_now;
    base    = a & 32'hFFFF_FFF0;
    line    = '0;
    aborted = 1'b0;

    req = 1'b1; kill = 1'b0; addr = a;
    bus_ack = 1'($urandom_range(0, 1)); bus_rdata = $urandom;
    #1;
    check_bus("accept", 1'b0, 1'b0, 32'h0, 1'b0);
    step();

    for (int b = 0; b < 4 && !aborted; b++) begin
      w = fixed ? 32'hA0 + 32'(b) : $urandom;
      line[b*32 +: 32] = w;
      for (int c = 0; c <= waits; c++) begin
        last   = (c == waits);
        ab_now = 1'b0;
        req = 1'b1; kill = 1'b0; addr = $urandom;
        bus_ack   = last;
        bus_rdata = last ? w : $urandom;
        if (b == ab_beat && c == 0) begin
          case (kind)
            K_KILL:  begin kill = 1'b1; bus_ack = 1'b0; ab_now = 1'b1; end
            K_DROP:  begin req = 1'b0;  bus_ack = 1'b0; ab_now = 1'b1; end
            K_RESET: begin rst_n = 1'b0; ab_now = 1'b1; end
            default: ;
          endcase
        end
        if (b == ab_beat && kind == K_KILL_ACK && last) begin
          kill = 1'b1; ab_now = 1'b1;
        end
        #1;
        check_bus($sformatf("beat%0d.wait%0d", b, c), 1'b1, 1'b1, base + 32'(4 * b), 1'b0);
        step();
        if (ab_now) begin
          aborted = 1'b1;
          break;
        end
      end
    end

    if (aborted && (kind == K_KILL || kind == K_DROP)) begin
      for (int d = 1; d <= drain_wait; d++) begin
        req = 1'($urandom_range(0, 1)); kill = 1'($urandom_range(0, 1));
        bus_ack = (d == drain_wait); bus_rdata = $urandom;
        #1;
        check_bus($sformatf("drain%0d", d), 1'b1, 1'b1, base + 32'(4 * ab_beat), 1'b0);
        step();
      end
    end else if (aborted && kind == K_RESET) begin
      rst_n = 1'b1; req = 1'b0; kill = 1'b0; bus_ack = 1'b0;
      #1;
      check_output("rst.busy", busy, 1'b0);
      check_output("rst.bus_req", bus_req, 1'b0);
      check_output("rst.ack", ack, 1'b0);
      check_output("rst.bus_addr", bus_addr, 32'h0);
      check_output("rst.r_data", r_data, 128'h0);
      step();
    end else if (!aborted) begin
      req = 1'b1; kill = 1'b0;
      if (ab_beat == 4 && kind == K_KILL) kill = 1'b1;
      if (ab_beat == 4 && kind == K_DROP) req = 1'b0;
      bus_ack = 1'($urandom_range(0, 1)); bus_rdata = $urandom;
      #1;
      check_bus("resp", 1'b1, 1'b0, 32'h0, ~(kill | ~req));
      if (!(kill | ~req)) check_output("resp.line", r_data, line);
      step();
    end
  endtask

  initial begin
    int kind;
    int ab_beat;
    rst_n = 1'b0; req = 1'b0; kill = 1'b0; addr = '0; bus_ack = 1'b0; bus_rdata = '0;
    step();
    step();
    check_output("reset.busy", busy, 1'b0);
    check_output("reset.bus_req", bus_req, 1'b0);
    check_output("reset.ack", ack, 1'b0);
    check_output("reset.bus_addr", bus_addr, 32'h0);
    check_output("reset.r_data", r_data, 128'h0);
    rst_n = 1'b1;
    step();

    fill(32'h8000_1234, 0, -1, K_NONE, 1, 1'b1);
    idle_step();
    fill(32'h1234_5678, 2, -1, K_NONE, 1, 1'b0);
    fill(32'h0000_0030, 1, 2, K_KILL, 3, 1'b0);
    fill(32'h0000_0040, 0, -1, K_NONE, 1, 1'b0);
    fill(32'hCAFE_0010, 0, 1, K_KILL_ACK, 1, 1'b0);
    fill(32'hCAFE_0020, 1, 4, K_KILL, 1, 1'b0);
    fill(32'hCAFE_0030, 0, 4, K_DROP, 1, 1'b0);
    fill(32'h0BAD_F00D, 1, 1, K_DROP, 2, 1'b0);
    fill(32'h7777_0004, 0, 3, K_RESET, 1, 1'b0);
    fill(32'h1111_2220, 0, -1, K_NONE, 1, 1'b0);
    fill(32'h3333_444C, 0, -1, K_NONE, 1, 1'b0);

    for (int i = 0; i < 24; i++) begin
      kind = $urandom_range(0, 3);
      if (kind == K_NONE) ab_beat = -1;
      else if (kind == K_KILL_ACK) ab_beat = $urandom_range(0, 3);
      else ab_beat = $urandom_range(0, 4);
      fill($urandom, $urandom_range(0, 2), ab_beat, kind, $urandom_range(1, 3), 1'b0);
      if ($urandom_range(0, 1) == 1) idle_step();
    end
    idle_step();

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule

// File: doc/icache_line_fill.md
Name: icache_line_fill

Overview:
- Refill bridge between the instruction cache miss port and the 32-bit instruction memory bus.
- Accepts one cache-line read request from the icache and issues LINE_WIDTH/BUS_WIDTH sequential word reads on the bus.
- Assembles the returned words into one line and returns it with a single-cycle ack.
- Honours icache kill/abort, and never retracts a bus read that has been issued but not yet acknowledged.

Parameters:
- ADDR_WIDTH, 32, byte address width on both sides.
- LINE_WIDTH, 128, cache line width in bits; returned on r_data_o.
- BUS_WIDTH, 32, memory bus data width in bits.
- Derived (localparam, not overridable): BEATS = LINE_WIDTH/BUS_WIDTH (4); BEAT_BITS = clog2(BEATS); LINE_OFF = clog2(LINE_WIDTH/8) (4).

Ports:
- clk  in  1  clock
- rst_n  in  1  reset, synchronous, active-low
- req_i  in  1  icache line read request; held high until ack_o or kill
- addr_i  in  ADDR_WIDTH  icache miss address (any byte within line)
- kill_i  in  1  icache abort pulse
- ack_o  out  1  line ready, one-cycle pulse
- r_data_o  out  LINE_WIDTH  assembled line; beat k in bits [k*BUS_WIDTH +: BUS_WIDTH]
- busy_o  out  1  high in any state other than IDLE
- bus_req_o  out  1  bus read request
- bus_addr_o  out  ADDR_WIDTH  bus word address
- bus_ack_i  in  1  bus read done; bus_rdata_i valid this cycle
- bus_rdata_i  in  BUS_WIDTH  bus read data

Behaviour:
- Reset: state = IDLE, beat counter = 0, base address = 0, line buffer = 0. All outputs are 0.
- Abort condition: abort = kill_i | ~req_i, evaluated in BEAT and RESP.
- IDLE:
  - On req_i & ~kill_i: latch base = {addr_i[ADDR_WIDTH-1:LINE_OFF], LINE_OFF'b0}, set beat = 0, go to BEAT.
  - The request is accepted the cycle it is seen; no bus activity occurs in that cycle.
- BEAT:
  - bus_req_o = 1; bus_addr_o = base + beat*(BUS_WIDTH/8). Both are registered or derived from registered state, and stay stable until bus_ack_i.
  - bus_ack_i may assert in any cycle bus_req_o is high, including the first.
  - On bus_ack_i with no abort: write bus_rdata_i into buffer slot [beat]. If beat == BEATS-1, go to RESP; otherwise beat++ and stay in BEAT. bus_req_o stays high and the new address appears the next cycle.
  - On abort with bus_ack_i in the same cycle: discard the data and go to IDLE.
  - On abort without bus_ack_i: go to DRAIN.
- DRAIN:
  - bus_req_o = 1 with the address unchanged; req_i and kill_i are ignored.
  - On bus_ack_i: discard the data and go to IDLE.
- RESP:
  - ack_o = ~abort; r_data_o = line buffer, which is valid whenever ack_o is high.
  - Always go to IDLE next cycle; when abort is high, no ack is issued.
- Outside RESP: r_data_o holds the buffer contents, but consumers must sample it only on ack_o.
- Latency: with a zero-wait bus, req accepted at cycle 0, beats in cycles 1..4, ack_o at cycle 5. Each wait cycle per beat adds 1 cycle.
- Back-to-back requests: after RESP, a new request can be accepted in IDLE on the following cycle, so the minimum request-to-request spacing is BEATS+2 cycles.
- Partial data from an aborted fill is never presented with ack_o. The buffer is overwritten by the next fill.
- bus_ack_i while bus_req_o = 0 is ignored.
- Reset asserted mid-operation: on the next edge, return to IDLE with all outputs 0. No drain is performed; the bus is reset by the same rst_n.

Test Plan:
- Zero-wait fill:
  - Stimulus: req_i with addr_i = 0x8000_1234; bus returns 0xA0, 0xA1, 0xA2, 0xA3 with bus_ack_i same cycle.
  - Required: bus_addr_o = 0x8000_1230/34/38/3C in cycles 1..4; ack_o only in cycle 5; r_data_o = {0xA3, 0xA2, 0xA1, 0xA0}.
- Wait states:
  - Stimulus: 2 wait cycles per beat.
  - Required: ack_o at cycle 13; bus_addr_o unchanged during each wait; busy_o high for cycles 1..13.
- Kill mid-beat:
  - Stimulus: kill_i during beat 2 with bus_ack_i low; bus acks 3 cycles later; icache reissues req to 0x0000_0040.
  - Required: enter DRAIN; bus_req_o high with address 0x...38 until the ack; no ack_o for the killed fill; new fill starts at 0x0000_0040.
- Kill with simultaneous bus_ack_i on beat 1:
  - Required: IDLE next cycle; bus_req_o = 0; no ack_o.
- Kill or req drop during RESP:
  - Required: ack_o stays 0; IDLE next cycle.
- Reset and back-to-back:
  - Stimulus: rst_n low during beat 3, then two consecutive requests.
  - Required: all outputs 0 the cycle after reset; two acks delivered 6 cycles apart on a zero-wait bus.
